// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: lock-gated h/v counters, sync/blank and a registered DAC stage.
// Optional VGA_TIMING_TEST_PATTERN_EN replaces pix_rgb with eight vertical colour bars.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_locked,
    output logic                   pix_req,
    output logic [9:0]             pix_x,
    output logic [9:0]             pix_y,
    input  logic [3*COLOR_W-1:0]   pix_rgb,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic                   vga_sync_n,
    output logic                   frame_start
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_params
        $error("vga_timing_gen: H_TOT and V_TOT must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST    = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOT - 1);
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        WAIT_LOCK,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;

    logic        lock_s;
    logic        run;
    logic        active;
    logic        hs_act;
    logic        vs_act;
    logic [10:0] h_ext;
    logic [10:0] v_ext;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [2:0] bar_q, bar_d;
    logic [9:0] bar_idx;
`endif

    always_comb begin
        sync1_d = pll_locked;
        sync2_d = sync1_q;
        lock_s  = sync2_q;

        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;

        case (state_q)
            WAIT_LOCK: begin
                h_d = '0;
                v_d = '0;
                if (lock_s) state_d = RUN;
            end
            RUN: begin
                // Losing lock aborts the frame; the raster restarts from (0,0) after re-lock.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    h_d     = '0;
                    v_d     = '0;
                end else if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
                end else begin
                    h_d = h_q + 10'd1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                h_d     = '0;
                v_d     = '0;
            end
        endcase

        h_ext  = {1'b0, h_q};
        v_ext  = {1'b0, v_q};
        run    = (state_q == RUN);
        active = run && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hs_act = run && (h_ext >= HS_BEGIN) && (h_ext < HS_END);
        vs_act = run && (v_ext >= VS_BEGIN) && (v_ext < VS_END);

        hs_d      = hs_act ? HS_POL : ~HS_POL;
        vs_d      = vs_act ? VS_POL : ~VS_POL;
        blank_n_d = active;

`ifdef VGA_TIMING_TEST_PATTERN_EN
        bar_idx = h_q / 10'(BAR_W);
        bar_d   = active ? bar_idx[2:0] : 3'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= WAIT_LOCK;
            h_q       <= '0;
            v_q       <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            bar_q     <= 3'd0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            bar_q     <= bar_d;
`endif
        end
    end

    assign pix_req     = active;
    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign frame_start = run && (h_q == 10'd0) && (v_q == 10'd0);
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;

    // pix_rgb arrives one cycle after pix_req, aligned with the registered blank flag.
`ifdef VGA_TIMING_TEST_PATTERN_EN
    assign vga_r = {COLOR_W{blank_n_q & bar_q[2]}};
    assign vga_g = {COLOR_W{blank_n_q & bar_q[1]}};
    assign vga_b = {COLOR_W{blank_n_q & bar_q[0]}};
`else
    assign vga_r = blank_n_q ? pix_rgb[3*COLOR_W-1 -: COLOR_W] : '0;
    assign vga_g = blank_n_q ? pix_rgb[2*COLOR_W-1 -: COLOR_W] : '0;
    assign vga_b = blank_n_q ? pix_rgb[COLOR_W-1:0]            : '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing, shortened vertical
// timing (20 active lines, 27 total) to keep frames short.
module tb_vga_timing_gen;

    localparam int H_TOT   = 800;
    localparam int V_TOT   = 27;
    localparam int FRAME   = H_TOT * V_TOT;
    localparam int ABORT_N = FRAME + 10 * H_TOT + 300;

    logic        clk;
    logic        rst;
    logic        pll_locked;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen #(
        .V_ACTIVE (20),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_sync_n  (vga_sync_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic test_reset();
        rst        = 1'b1;
        pll_locked = 1'b1;
        pix_rgb    = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_req, frame_start} !== 2'b00) begin
            failures++;
            $display("FAIL reset_req_fs: got %b expected 00", {pix_req, frame_start});
        end
        checks++;
        if ({pix_x, pix_y} !== 20'd0) begin
            failures++;
            $display("FAIL reset_xy: got x=%0d y=%0d expected 0/0", pix_x, pix_y);
        end
        checks++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_sync_n} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_sync: got hs/vs/blank_n/sync_n=%b expected 1100",
                     {vga_hs, vga_vs, vga_blank_n, vga_sync_n});
        end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0) begin
            failures++;
            $display("FAIL reset_rgb: got %h expected 000000", {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_wait_lock();
        int bad;
        bad        = 0;
        rst        = 1'b0;
        pll_locked = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checks++;
            if ({pix_req, vga_hs, vga_vs, frame_start, vga_blank_n} !== 5'b01100) begin
                failures++;
                if (bad < 5)
                    $display("FAIL wait_lock cycle %0d: got req/hs/vs/fs/blank_n=%b expected 01100",
                             i, {pix_req, vga_hs, vga_vs, frame_start, vga_blank_n});
                bad++;
            end
        end
    endtask

    task automatic test_lock_latency();
        pll_locked = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (pix_req !== 1'b0) begin
                failures++;
                $display("FAIL lock_latency_early k=%0d: got pix_req=%b expected 0", k, pix_req);
            end
        end
    endtask

    // Sample n = 0 is the third edge after lock; model derives everything from n.
    task automatic test_free_run();
        int h, v, hp, vp;
        int hs_low_line0, vs_low_frame0, fs_first, fs_second, fs_count, bad;
        logic act, act_p, hs_e, vs_e, fs_e;
        logic [2:0]  bar;
        logic [23:0] rgb_e;
        logic [49:0] obs, exp_v;
        hs_low_line0 = 0; vs_low_frame0 = 0; fs_first = -1; fs_second = -1; fs_count = 0; bad = 0;
        for (int n = 0; n <= ABORT_N; n++) begin
            h     = n % H_TOT;
            v     = (n / H_TOT) % V_TOT;
            hp    = (n == 0) ? 0 : (n - 1) % H_TOT;
            vp    = (n == 0) ? 0 : ((n - 1) / H_TOT) % V_TOT;
            act   = (h < 640) && (v < 20);
            act_p = (n > 0) && (hp < 640) && (vp < 20);
            hs_e  = !((n > 0) && hp >= 656 && hp < 752);
            vs_e  = !((n > 0) && vp >= 22 && vp < 24);
            fs_e  = (h == 0) && (v == 0);
            bar   = 3'(hp / 80);
`ifdef VGA_TIMING_TEST_PATTERN_EN
            rgb_e = act_p ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : 24'h0;
`else
            rgb_e = act_p ? 24'hAA55F0 : 24'h0;
`endif
            @(negedge clk);
            pix_rgb = act_p ? 24'hAA55F0 : 24'h123456;
            #1;
            obs   = {pix_req, pix_x, pix_y, frame_start, vga_hs, vga_vs, vga_blank_n,
                     vga_r, vga_g, vga_b, vga_sync_n};
            exp_v = {act, 10'(h), 10'(v), fs_e, hs_e, vs_e, act_p, rgb_e, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                if (bad < 10)
                    $display("FAIL free_run n=%0d: got %h expected %h (req,x,y,fs,hs,vs,blank_n,rgb,sync_n)",
                             n, obs, exp_v);
                bad++;
            end
            if (n < H_TOT && vga_hs === 1'b0) hs_low_line0++;
            if (n < FRAME && vga_vs === 1'b0) vs_low_frame0++;
            if (frame_start === 1'b1) begin
                fs_count++;
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
        end
        pll_locked = 1'b0;
        checks++;
        if (hs_low_line0 !== 96) begin
            failures++;
            $display("FAIL hs_width: got %0d cycles expected 96", hs_low_line0);
        end
        checks++;
        if (vs_low_frame0 !== 1600) begin
            failures++;
            $display("FAIL vs_width: got %0d cycles expected 1600", vs_low_frame0);
        end
        checks++;
        if (fs_count !== 2 || fs_second - fs_first !== FRAME) begin
            failures++;
            $display("FAIL frame_period: got count=%0d period=%0d expected 2/%0d",
                     fs_count, fs_second - fs_first, FRAME);
        end
    endtask

    task automatic test_abort_relock();
        pix_rgb = 24'h123456;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if ({pix_req, pix_x} !== {1'b1, 10'(300 + k)}) begin
                failures++;
                $display("FAIL abort_run k=%0d: got req=%b x=%0d expected 1/%0d", k, pix_req, pix_x, 300 + k);
            end
        end
        @(negedge clk);
        checks++;
        if ({pix_req, frame_start, pix_x, pix_y} !== 22'd0) begin
            failures++;
            $display("FAIL abort_clear: got req=%b fs=%b x=%0d y=%0d expected all 0",
                     pix_req, frame_start, pix_x, pix_y);
        end
        @(negedge clk);
        checks++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b} !== {3'b110, 24'h0}) begin
            failures++;
            $display("FAIL abort_sync: got hs=%b vs=%b blank_n=%b rgb=%h expected 1/1/0/000000",
                     vga_hs, vga_vs, vga_blank_n, {vga_r, vga_g, vga_b});
        end
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pix_req !== 1'b0) begin
            failures++;
            $display("FAIL relock_early: got pix_req=%b expected 0", pix_req);
        end
        @(negedge clk);
        checks++;
        if ({pix_req, frame_start, pix_x, pix_y} !== {2'b11, 20'd0}) begin
            failures++;
            $display("FAIL relock_start: got req=%b fs=%b x=%0d y=%0d expected 1/1/0/0",
                     pix_req, frame_start, pix_x, pix_y);
        end
        @(negedge clk);
        checks++;
        if ({vga_blank_n, frame_start, pix_x} !== {2'b10, 10'd1}) begin
            failures++;
            $display("FAIL relock_next: got blank_n=%b fs=%b x=%0d expected 1/0/1",
                     vga_blank_n, frame_start, pix_x);
        end
    endtask

    task automatic test_reset_midframe();
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({pix_req, frame_start, pix_x, pix_y, vga_hs, vga_vs, vga_blank_n} !== {2'b00, 20'd0, 3'b110}) begin
            failures++;
            $display("FAIL reset_midframe: got req=%b fs=%b x=%0d y=%0d hs=%b vs=%b blank_n=%b expected 0/0/0/0/1/1/0",
                     pix_req, frame_start, pix_x, pix_y, vga_hs, vga_vs, vga_blank_n);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pix_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_relock_early: got pix_req=%b expected 0", pix_req);
        end
        @(negedge clk);
        checks++;
        if ({pix_req, frame_start, pix_x, pix_y} !== {2'b11, 20'd0}) begin
            failures++;
            $display("FAIL reset_relock_start: got req=%b fs=%b x=%0d y=%0d expected 1/1/0/0",
                     pix_req, frame_start, pix_x, pix_y);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        pix_rgb    = 24'h0;
        test_reset();
        test_wait_lock();
        test_lock_latency();
        test_free_run();
        test_abort_relock();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
